// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Canonical ADDI x0,x0,0; decode substitutes it on bubbles.
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and flush; flush overrides push and pop.
// The head entry is read straight from the storage registers, so it is stable while not popped.
module sync_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [63:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output entry_t                       head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, issues credit-limited imem requests and buffers
// in-order responses with their PCs. Define FETCH_TRACE_EN to print handshakes and redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc
);

    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          run_q;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic [31:0]   redirect_pc;
    logic [CW:0]   inflight;
    logic          req_valid, req_fire, rsp_drop, push, pop;

    assign redirect_pc = i_redirect_pc & ~32'h3;
    // Requests whose responses will be dropped still hold a credit until they return.
    assign inflight    = {1'b0, outstanding_q} + {1'b0, count};
    assign req_valid   = run_q & ~i_redirect & (inflight < DEPTH_C);
    assign req_fire    = req_valid & i_imem_req_ready;
    assign rsp_drop    = i_imem_rsp_valid & (drop_cnt_q != '0);
    assign push        = i_imem_rsp_valid & ~rsp_drop & ~i_redirect;
    assign pop         = o_instr_valid & i_instr_ready;
    assign push_entry  = '{pc: rsp_pc_q, instr: i_imem_rsp_data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q - CW'(rsp_drop);
        if (req_fire) fetch_pc_d = pc_plus4(fetch_pc_q);
        if (push)     rsp_pc_d   = pc_plus4(rsp_pc_q);
        if (i_redirect) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_cnt_d = outstanding_q - CW'(i_imem_rsp_valid);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            run_q         <= 1'b1;
        end
    end

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (i_redirect),
        .count_o     (count),
        .head_o      (head)
    );

    assign o_imem_req_valid = req_valid;
    assign o_imem_addr      = fetch_pc_q;
    assign o_instr_valid    = (count != '0);
    assign o_instr          = head.instr;
    assign o_instr_pc       = head.pc;

`ifdef FETCH_TRACE_EN
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            if (pop)        $display("IF PC=%08x INSTR=%08x", head.pc, head.instr);
            if (i_redirect) $display("IF REDIRECT PC=%08x DROP=%0d", redirect_pc, drop_cnt_d);
        end
    end
`else
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Owns the fetch PC, issues word requests to a variable-latency instruction memory over a valid/ready request channel, and buffers in-order responses with their PCs in a small FIFO. Hands instructions to decode over a valid/ready channel. Redirects flush the FIFO and discard responses still in flight.

## Interface
- `DEPTH`, 4: FIFO entries and the maximum number of in-flight requests; a power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_redirect` input 1: core requests a PC redirect (branch, jump).
- `i_redirect_pc` input 32: redirect target; bits [1:0] ignored and treated as 0.
- `o_imem_req_valid` output 1: request valid.
- `i_imem_req_ready` input 1: memory accepts the request.
- `o_imem_addr` output 32: word-aligned request address.
- `i_imem_rsp_valid` input 1: response valid; in order, one per accepted request.
- `i_imem_rsp_data` input 32: response instruction word.
- `o_instr_valid` output 1: instruction available to decode.
- `i_instr_ready` input 1: decode accepts the instruction.
- `o_instr` output 32: instruction at the FIFO head.
- `o_instr_pc` output 32: PC of `o_instr`.

## Operation
- Registers: `fetch_pc`, `rsp_pc`, `outstanding` (0..DEPTH), `drop_cnt` (0..DEPTH), `run_q`, FIFO `count`.
- Reset values: `fetch_pc = rsp_pc = RESET_PC`; all counters 0; `run_q = 0`; FIFO empty.
- Reset outputs: `o_imem_req_valid = 0`, `o_instr_valid = 0`, `o_imem_addr = RESET_PC`, `o_instr = 0`, `o_instr_pc = 0`.
- `run_q` sets on the first rising edge after reset is released. The first request goes out in the following cycle.
- `o_imem_req_valid = run_q & !i_redirect & (outstanding + count < DEPTH)`.
  - Requests for responses pending discard count as outstanding.
  - Under this rule the FIFO never overflows.
- `o_imem_addr = fetch_pc`.
- Request handshake (valid & ready): `fetch_pc += 4` and `outstanding++`.
- Response (`i_imem_rsp_valid`): `outstanding--`.
  - If `drop_cnt > 0`, the data is discarded and `drop_cnt--`.
  - Otherwise `{rsp_pc, data}` is pushed to the FIFO and `rsp_pc += 4`.
- Pop happens on `o_instr_valid & i_instr_ready`. `o_instr_valid = (count != 0)`.
- Redirect cycle:
  - `fetch_pc` and `rsp_pc` load `{i_redirect_pc[31:2], 2'b00}`.
  - The FIFO is flushed, and the flush overrides any push or pop in that cycle.
  - `drop_cnt` loads the next value of `outstanding`, i.e. `outstanding - i_imem_rsp_valid`. Any response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the later one wins. `drop_cnt` is recomputed from `outstanding` each time.
- Address arithmetic is 32-bit modulo. `0xFFFF_FFFC + 4` wraps to 0.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are the memory's responsibility: it is reset on the same `i_rst_n`.

## Timing
- Request to instruction: a request accepted in cycle t with its response in t+1 pushes at the end of t+1. `o_instr_valid` rises in t+2, giving a 2-cycle latency for a zero-wait memory.
- Throughput: 1 instruction per cycle sustained with `DEPTH ≥ 4` and a 1-cycle memory.
- Redirect in cycle t:
  - `o_instr_valid = 0` in t+1.
  - The first request to the target is issued in t+1.
  - The first target instruction is visible at the earliest in t+3, once dropped responses have drained.
- `o_imem_req_valid` may drop without a handshake only because of redirect, credit or reset. Otherwise, once asserted, it holds with a stable address until ready.
- `o_instr`, `o_instr_pc` and `o_instr_valid` come from registers (FIFO head) and are stable while stalled.

## Configuration
- `FETCH_TRACE_EN` defined: on every decode handshake, prints `IF PC=%08x INSTR=%08x`. On every redirect, prints `IF REDIRECT PC=%08x DROP=%0d`.
- Undefined: no `$display`; the logic is identical.

## Structure
- `fetch_pkg` holds:
  - `XLEN = 32`;
  - `fetch_entry_t` packed struct `{logic [31:0] pc; logic [31:0] instr;}`;
  - `INSTR_NOP = 32'h0000_0013`, used by decode on bubbles.
- Sub-module `sync_fifo`, parameterized by `DEPTH` and entry type. It has push, pop, flush, count and head ports. Flush has priority over push and pop.

## Test plan
- Zero-wait memory (ready=1, rsp next cycle), `RESET_PC=0`, decode always ready → addresses 0,4,8,… issued every cycle after `run_q`. Instructions appear 2 cycles later with matching `o_instr_pc`, one per cycle.
- Decode holds `i_instr_ready = 0` for 10 cycles → exactly 4 requests outstanding+buffered, `o_imem_req_valid` low, `o_instr`/`o_instr_pc` stable. On release, the stream resumes with no gaps or duplicates.
- Memory with 3-cycle response latency, 2 requests in flight, redirect to `0x100` → both stale responses dropped. The first delivered instruction has `o_instr_pc = 0x100`, and `drop_cnt` returns to 0.
- Redirect to `0x203` in the same cycle as a response and a decode pop → FIFO empty next cycle, the response is discarded, and the next fetch address is `0x200`.
- `RESET_PC = 0xFFFF_FFF8` → addresses `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`. Asserting `i_rst_n = 0` mid-stream drops `o_instr_valid` and `o_imem_req_valid` immediately, without a clock edge.
- Memory deasserts `i_imem_req_ready` for 5 cycles → `o_imem_addr` holds steady, `fetch_pc` does not advance, and no response is expected.
